// File: rtl/pong_game_ctrl.sv
// Match sequencer for the pong pipeline: serve/play/pause/point/over states,
// score keeping and ball mover gating, paced by vsync rising edges.
`timescale 1ns/1ps
module pong_game_ctrl #(
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int WIN_SCORE    = 7,
   parameter int LEFT_LIMIT   = 10,
   parameter int RIGHT_LIMIT  = 630
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic       start_btn,
   input  logic [9:0] ball_x_pos,
   output logic       ball_run,
   output logic       ball_load,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_POINT = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CW = $clog2(MAX_FRAMES) + 1;
   localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
   localparam logic [CW-1:0] POINT_LAST = CW'(POINT_FRAMES - 1);
   localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
   localparam logic [9:0]    LEFT       = 10'(LEFT_LIMIT);
   localparam logic [9:0]    RIGHT      = 10'(RIGHT_LIMIT);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    score_l_q, score_l_d;
   logic [3:0]    score_r_q, score_r_d;
   logic          serve_dir_q, serve_dir_d;
   logic          ball_load_q, ball_load_d;
   logic          vsync_prev_q;
   logic          start_meta_q, start_sync_q, start_prev_q;
   logic          frame_tick, start_evt;

   // vsync history resets high so a held-high vsync never looks like an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         score_l_q    <= '0;
         score_r_q    <= '0;
         serve_dir_q  <= 1'b0;
         ball_load_q  <= 1'b0;
         vsync_prev_q <= 1'b1;
         start_meta_q <= 1'b0;
         start_sync_q <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         serve_dir_q  <= serve_dir_d;
         ball_load_q  <= ball_load_d;
         vsync_prev_q <= vsync;
         start_meta_q <= start_btn;
         start_sync_q <= start_meta_q;
         start_prev_q <= start_sync_q;
      end
   end

   always_comb begin
      frame_tick  = vsync & ~vsync_prev_q;
      start_evt   = start_sync_q & ~start_prev_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      serve_dir_d = serve_dir_q;
      ball_load_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_evt) begin
               score_l_d   = '0;
               score_r_d   = '0;
               serve_dir_d = 1'b1;
               cnt_d       = '0;
               ball_load_d = 1'b1;
               state_d     = S_SERVE;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (cnt_q == SERVE_LAST) state_d = S_PLAY;
               else                     cnt_d   = cnt_q + CW'(1);
            end
         end
         S_PLAY: begin
            // a miss on the tick takes priority over a coincident pause request
            if (frame_tick && (ball_x_pos <= LEFT)) begin
               if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
               serve_dir_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_POINT;
            end else if (frame_tick && (ball_x_pos >= RIGHT)) begin
               if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
               serve_dir_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_POINT;
            end else if (start_evt) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (start_evt) state_d = S_PLAY;
         end
         S_POINT: begin
            if (frame_tick) begin
               if (cnt_q == POINT_LAST) begin
                  cnt_d = '0;
                  if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                     state_d = S_OVER;
                  end else begin
                     ball_load_d = 1'b1;
                     state_d     = S_SERVE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_OVER: begin
            if (start_evt) begin
               score_l_d   = '0;
               score_r_d   = '0;
               cnt_d       = '0;
               ball_load_d = 1'b1;
               state_d     = S_SERVE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ball_run  = (state_q == S_PLAY);
   assign game_over = (state_q == S_OVER);
   assign ball_load = ball_load_q;
   assign serve_dir = serve_dir_q;
   assign score_l   = score_l_q;
   assign score_r   = score_r_q;
   assign state     = state_q;

endmodule
